// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// After each write strobe it holds off for one full frame plus guard time.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FRAME_BITS   = 10,
    parameter int unsigned GUARD_BITS   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [7:0]             o_tx_bin,
    output logic                   o_tx_write,
    output logic                   o_busy,
    output logic [1:0]             o_grant_id
);

    localparam int unsigned HOLD  = (FRAME_BITS + GUARD_BITS) * CLKS_PER_BIT;
    localparam int unsigned CNT_W = $clog2(HOLD + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [1:0]       last_grant;
    logic             hit;
    logic             take;
    logic [1:0]       pick;
    logic [7:0]       pick_data;

    // Search starts just above the last grant, so the previous winner ranks last.
    always_comb begin
        hit       = 1'b0;
        pick      = '0;
        pick_data = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!hit && i_req_valid[k] && (k == (32'(last_grant) + i) % NUM_REQ)) begin
                    hit  = 1'b1;
                    pick = 2'(k);
                end
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick == 2'(k)) pick_data = i_req_data[8*k +: 8];
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        o_req_ready = '0;
        take        = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    take       = 1'b1;
                    state_next = ISSUE;
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        o_req_ready[k] = (pick == 2'(k));
                    end
                end
            end
            ISSUE: begin
                count_next = CNT_W'(HOLD - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (count == '0) state_next = IDLE;
                else             count_next = count - CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            count      <= '0;
            o_tx_bin   <= '0;
            o_grant_id <= '0;
            last_grant <= 2'(NUM_REQ - 1);
        end else begin
            state <= state_next;
            count <= count_next;
            if (take) begin
                o_tx_bin   <= pick_data;
                o_grant_id <= pick;
                last_grant <= pick;
            end
        end
    end

    assign o_tx_write = (state == ISSUE);
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 2-requester and a 3-requester instance,
// CLKS_PER_BIT = 4 so the grant spacing is 46 cycles.
module tb_uart_tx_arbiter;

    typedef struct {
        int         cyc;
        logic [7:0] bin;
        logic [1:0] id;
    } strobe_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  valid_a = '0;
    logic [15:0] data_a  = '0;
    logic [1:0]  ready_a;
    logic [7:0]  bin_a;
    logic        write_a, busy_a;
    logic [1:0]  id_a;

    logic [2:0]  valid_b = '0;
    logic [23:0] data_b  = '0;
    logic [2:0]  ready_b;
    logic [7:0]  bin_b;
    logic        write_b, busy_b;
    logic [1:0]  id_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int bad_rule = 0;
    int max_id_b = 0;
    int n, rdy_cyc;
    strobe_t qa[$];
    strobe_t qb[$];
    strobe_t sa, sb;

    uart_tx_arbiter #(.NUM_REQ(2), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GUARD_BITS(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid_a), .i_req_data(data_a),
        .o_req_ready(ready_a), .o_tx_bin(bin_a), .o_tx_write(write_a),
        .o_busy(busy_a), .o_grant_id(id_a)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GUARD_BITS(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid_b), .i_req_data(data_b),
        .o_req_ready(ready_b), .o_tx_bin(bin_b), .o_tx_write(write_b),
        .o_busy(busy_b), .o_grant_id(id_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_a) begin
            sa.cyc = cyc; sa.bin = bin_a; sa.id = id_a;
            qa.push_back(sa);
        end
        if (write_b) begin
            sb.cyc = cyc; sb.bin = bin_b; sb.id = id_b;
            qb.push_back(sb);
        end
        if ((ready_a & ~valid_a) != 0 || (busy_a && ready_a != 0) || $countones(ready_a) > 1)
            bad_rule++;
        if ((ready_b & ~valid_b) != 0 || (busy_b && ready_b != 0) || $countones(ready_b) > 1)
            bad_rule++;
        if (int'(id_b) > max_id_b) max_id_b = int'(id_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_a(input int k, input logic [7:0] b);
        int i;
        @(posedge clk); #1;
        valid_a[k] = 1'b1;
        data_a[8*k +: 8] = b;
        i = 0;
        @(negedge clk);
        while (!ready_a[k] && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("send_ready", 32'(ready_a[k]), 32'd1);
        @(posedge clk); #1;
        valid_a[k] = 1'b0;
    endtask

    task automatic wait_a(input int cnt);
        for (int i = 0; i < 500 && qa.size() < cnt; i++) @(posedge clk);
        check("strobe_count_a", qa.size(), cnt);
    endtask

    task automatic wait_b(input int cnt);
        for (int i = 0; i < 500 && qb.size() < cnt; i++) @(posedge clk);
        check("strobe_count_b", qb.size(), cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(negedge clk);
        check("rst_busy",  32'(busy_a),  0);
        check("rst_write", 32'(write_a), 0);
        check("rst_bin",   32'(bin_a),   0);
        check("rst_id",    32'(id_a),    0);
        check("rst_ready", 32'(ready_a), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // single request
        valid_a = 2'b01;
        data_a[7:0] = 8'hA5;
        @(negedge clk);
        check("single_ready", 32'(ready_a), 32'b01);
        check("single_idle",  32'(busy_a),  0);
        rdy_cyc = cyc;
        @(posedge clk); #1;
        valid_a = '0;
        @(negedge clk);
        check("single_write", 32'(write_a), 1);
        check("single_bin",   32'(bin_a),   32'hA5);
        check("single_id",    32'(id_a),    0);
        check("single_busy",  32'(busy_a),  1);
        check("single_nordy", 32'(ready_a), 0);
        n = 1;
        while (busy_a && n < 200) begin
            @(negedge clk);
            if (busy_a) n++;
        end
        check("single_busy_len", n, 45);
        check("single_idle_cyc", cyc - rdy_cyc, 46);

        // back-to-back on requester 1
        qa.delete();
        send_a(1, 8'h30);
        send_a(1, 8'h31);
        send_a(1, 8'h32);
        wait_a(3);
        if (qa.size() >= 3) begin
            check("b2b_bin0", 32'(qa[0].bin), 32'h30);
            check("b2b_bin1", 32'(qa[1].bin), 32'h31);
            check("b2b_bin2", 32'(qa[2].bin), 32'h32);
            check("b2b_id",   32'(qa[2].id),  1);
            check("b2b_gap1", qa[1].cyc - qa[0].cyc, 46);
            check("b2b_gap2", qa[2].cyc - qa[1].cyc, 46);
        end

        // valid arriving during WAIT
        qa.delete();
        send_a(1, 8'h40);
        repeat (11) @(posedge clk);
        #1;
        valid_a[0] = 1'b1;
        data_a[7:0] = 8'h55;
        @(negedge clk);
        check("wait_noready", 32'(ready_a), 0);
        check("wait_busy",    32'(busy_a),  1);
        n = 0;
        while (!ready_a[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        rdy_cyc = cyc;
        @(posedge clk); #1;
        valid_a = '0;
        wait_a(2);
        if (qa.size() >= 2) begin
            check("wait_grant_cyc", rdy_cyc - qa[0].cyc, 45);
            check("wait_bin",       32'(qa[1].bin), 32'h55);
            check("wait_gap",       qa[1].cyc - qa[0].cyc, 46);
        end
        repeat (3) @(posedge clk);
        check("wait_no_extra", qa.size(), 2);

        // reset 20 cycles into WAIT
        send_a(1, 8'h66);
        repeat (21) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy_a), 1);
        check("pre_rst_id",   32'(id_a),   1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy_a),  0);
        check("mid_rst_write", 32'(write_a), 0);
        check("mid_rst_bin",   32'(bin_a),   0);
        check("mid_rst_id",    32'(id_a),    0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        qa.delete();

        // simultaneous requests after reset: req0 first, then alternate
        valid_a = 2'b11;
        data_a  = {8'h22, 8'h11};
        @(negedge clk);
        check("rst_prio", 32'(ready_a), 32'b01);
        wait_a(4);
        valid_a = '0;
        if (qa.size() >= 4) begin
            check("sim_bin0", 32'(qa[0].bin), 32'h11);
            check("sim_bin1", 32'(qa[1].bin), 32'h22);
            check("sim_bin2", 32'(qa[2].bin), 32'h11);
            check("sim_bin3", 32'(qa[3].bin), 32'h22);
            check("sim_id0",  32'(qa[0].id),  0);
            check("sim_id1",  32'(qa[1].id),  1);
            check("sim_id3",  32'(qa[3].id),  1);
            check("sim_gap1", qa[1].cyc - qa[0].cyc, 46);
            check("sim_gap3", qa[3].cyc - qa[2].cyc, 46);
        end

        // three-way wrap
        qb.delete();
        @(posedge clk); #1;
        valid_b = 3'b111;
        data_b  = {8'hC2, 8'hB1, 8'hA0};
        wait_b(4);
        valid_b = '0;
        if (qb.size() >= 4) begin
            check("wrap_id0",  32'(qb[0].id),  0);
            check("wrap_id1",  32'(qb[1].id),  1);
            check("wrap_id2",  32'(qb[2].id),  2);
            check("wrap_id3",  32'(qb[3].id),  0);
            check("wrap_bin2", 32'(qb[2].bin), 32'hC2);
            check("wrap_bin3", 32'(qb[3].bin), 32'hA0);
            check("wrap_gap",  qb[3].cyc - qb[2].cyc, 46);
        end
        repeat (50) @(posedge clk);
        check("max_id_b",   max_id_b, 2);
        check("ready_rule", bad_rule, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `NUM_REQ` byte sources, for example the RX echo path and a status/message generator. Each source uses a valid/ready byte handshake. The arbiter grants round-robin, drives the transmitter's byte and write-strobe inputs, and then enforces a frame hold-off timed from `CLKS_PER_BIT`, so the transmitter needs no busy output. It sits between the byte producers and the transmitter in the top level.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2–4.
- `CLKS_PER_BIT`, default 217: clocks per UART bit (25 MHz / 115200); must match the transmitter.
- `FRAME_BITS`, default 10: bits per frame (start + 8 data + stop).
- `GUARD_BITS`, default 1: extra idle bit-times inserted after each frame.
- `i_clk` input 1: system clock; all state updates on its rising edge.
- `i_rst` input 1: reset, asynchronous and active-high.
- `i_req_valid` input `NUM_REQ`: per-requester byte-valid.
- `i_req_data` input `8*NUM_REQ`: requester k's byte is on bits [8k+7:8k].
- `o_req_ready` output `NUM_REQ`: one-hot grant; a transfer occurs when valid[k] & ready[k] are both high at a clock edge.
- `o_tx_bin` output 8: byte to the transmitter; held until the next grant.
- `o_tx_write` output 1: one-cycle write strobe to the transmitter.
- `o_busy` output 1: high in ISSUE and WAIT.
- `o_grant_id` output 2: index of the most recently granted requester.

## Operation
- **States:** IDLE, ISSUE, WAIT. The state register, `o_tx_bin`, `o_grant_id`, the last-grant pointer and the hold counter are all registered.
- **HOLD:** HOLD = (FRAME_BITS + GUARD_BITS) * CLKS_PER_BIT. The counter is wide enough for HOLD and is sized with `$clog2`.
- **IDLE:**
  - `o_req_ready` is combinational: one-hot for the first valid requester, searching from last_grant+1 upward and wrapping modulo `NUM_REQ`.
  - `o_req_ready` is all-zero when no requester is valid, and always all-zero outside IDLE.
  - On a transfer: latch the granted byte into `o_tx_bin`, set `o_grant_id` and last_grant to k, go to ISSUE.
- **ISSUE:** `o_tx_write` = 1 for exactly this cycle. Load the counter with HOLD-1 and go to WAIT.
- **WAIT:** decrement the counter each cycle. When it is 0, go to IDLE. Valid inputs are ignored in WAIT; no ready is asserted.
- **Requester rules:**
  - A requester holds valid and data stable until it sees ready.
  - Deasserting valid before a grant is legal; that requester is simply skipped.
  - The arbiter never asserts ready to a requester whose valid is low.
- **Simultaneous valids:** the round-robin order decides. A requester granted last has the lowest priority next time.
- **Reset values:** state IDLE, `o_tx_write` 0, `o_tx_bin` 8'h00, `o_grant_id` 0, last_grant `NUM_REQ`-1 (so requester 0 has first priority), counter 0, `o_busy` 0.
  - In reset `o_req_ready` follows IDLE rules, but no transfer is registered while `i_rst` is high.
- **Reset mid-operation:** asserting `i_rst` in ISSUE or WAIT returns to IDLE immediately and kills any pending strobe. The transmitter is not reset by this block; a frame already in flight on the line is its concern.
- **Out-of-range index:** with `NUM_REQ` < 4, `o_grant_id` never exceeds `NUM_REQ`-1.

## Timing
- **Grant cycle:** grant at edge T (IDLE, valid & ready). State is ISSUE in cycle T+1, with `o_tx_write` = 1 and `o_tx_bin` valid.
- **Hold-off:** WAIT occupies cycles T+2 through T+1+HOLD. IDLE resumes at T+2+HOLD; a new grant can complete at that edge.
- **Minimum grant spacing:** HOLD + 2 cycles. With CLKS_PER_BIT = 4, FRAME_BITS = 10 and GUARD_BITS = 1, HOLD = 44 and the spacing is 46 cycles.
- **`o_tx_bin` stability:** stable from T+1 until the next grant edge, well beyond the transmitter's sampling of the strobe.
- **Ready path:** no combinational path from `i_req_data` to any output. `o_req_ready` depends combinationally only on `i_req_valid` and state.
- **`o_busy`:** equals (state != IDLE), registered-state decoded.

## Test plan
All cases use NUM_REQ = 2, CLKS_PER_BIT = 4 unless stated.
- **Single request:** req0 valid with 8'hA5 from cycle 5 → `o_req_ready`[0] high in cycle 5; `o_tx_write` pulse in cycle 6 with `o_tx_bin` = A5; `o_busy` high cycles 6–50, low at 51.
- **Simultaneous requests:** req0 = 8'h11 and req1 = 8'h22 held continuously → writes alternate 11, 22, 11, 22, exactly 46 cycles apart; `o_grant_id` alternates 0, 1.
- **Back-to-back on one source:** req1 only, three bytes 8'h30/31/32 → three strobes 46 cycles apart in order; req0 never readied.
- **Valid arriving during WAIT:** req0 raises valid 10 cycles into WAIT → no ready until IDLE is re-entered; granted on the first IDLE cycle; `o_tx_write` never pulses during WAIT.
- **Reset mid-operation:** assert `i_rst` for 2 cycles, 20 cycles into WAIT → `o_busy`, `o_tx_write`, `o_tx_bin` and `o_grant_id` read 0 asynchronously; the next request after release is granted immediately with req0 priority.
- **Three-way wrap (NUM_REQ = 3):** all valid → grant order 0, 1, 2, 0; `o_grant_id` never reads 3.
